traffic_sensor_conditioner: RTL



---
 rtl/light_package.sv | 24 ++
 rtl/sensor_lane.sv | 123 ++++++++++++
 rtl/traffic_sensor_conditioner.sv | 56 +++++
 3 files changed

// File: rtl/light_package.sv
// rtl/light_package.sv - light colours, lane state encoding and lane indices shared by controller and conditioner
package light_package;

  typedef enum logic [1:0] {
    red    = 2'b00,
    yellow = 2'b01,
    green  = 2'b10
  } colors;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    QUAL  = 2'b01,
    REQ   = 2'b10,
    SERVE = 2'b11
  } lane_state_t;

  localparam int NUM_LANES   = 5;
  localparam int LANE_E_STR  = 0;
  localparam int LANE_W_STR  = 1;
  localparam int LANE_E_LEFT = 2;
  localparam int LANE_W_LEFT = 3;
  localparam int LANE_NS     = 4;

endpackage

// File: rtl/sensor_lane.sv
// rtl/sensor_lane.sv - one lane: synchroniser, debounce, request latch until served, optional wait counter
// Wait counter and alarm exist only when TSC_WAIT_ALARM_EN is defined.
module sensor_lane
  import light_package::*;
#(
  parameter int DEBOUNCE   = 3,
  parameter int CLEAR_HOLD = 2,
  parameter int MAX_WAIT   = 255
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic raw_i,
  input  logic is_green_i,
  output logic sensor_o,
  output logic wait_alarm_o
);

  localparam logic [3:0] DEB_LAST = 4'(DEBOUNCE - 1);
  localparam logic [3:0] CLR_LAST = 4'(CLEAR_HOLD - 1);

  if (DEBOUNCE < 2 || DEBOUNCE > 15 || CLEAR_HOLD < 1 || CLEAR_HOLD > 15 ||
      MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_bad_cfg
    $error("sensor_lane: parameter out of legal range");
  end

  logic        s1_q, s2_q;
  lane_state_t state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  clr_q, clr_d;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      clr_q   <= 4'd0;
    end else begin
      s1_q    <= raw_i;
      s2_q    <= s1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      clr_q   <= clr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_d   = clr_q;
    case (state_q)
      IDLE: begin
        if (s2_q) begin
          state_d = QUAL;
          cnt_d   = 4'd1;
        end
      end
      QUAL: begin
        if (!s2_q) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = REQ;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      REQ: begin
        if (is_green_i) begin
          state_d = SERVE;
          clr_d   = 4'd0;
        end
      end
      SERVE: begin
        // Traffic cleared wins over the light leaving green in the same cycle.
        if (!s2_q && clr_q == CLR_LAST) begin
          state_d = IDLE;
          clr_d   = 4'd0;
        end else if (!is_green_i) begin
          state_d = s2_q ? REQ : IDLE;
          clr_d   = 4'd0;
        end else begin
          clr_d = s2_q ? 4'd0 : clr_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        clr_d   = 4'd0;
      end
    endcase
  end

  assign sensor_o = (state_q == REQ) || (state_q == SERVE);

`ifdef TSC_WAIT_ALARM_EN
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [7:0] wait_q, wait_d;

  // Counts only while staying in REQ, so every entry into REQ starts from zero.
  always_comb begin
    wait_d = 8'd0;
    if (state_q == REQ && state_d == REQ) begin
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_q <= 8'd0;
    end else begin
      wait_q <= wait_d;
    end
  end

  assign wait_alarm_o = (state_q == REQ) && (wait_q == WAIT_MAX);
`else
  assign wait_alarm_o = 1'b0;
`endif

endmodule

// File: rtl/traffic_sensor_conditioner.sv
// rtl/traffic_sensor_conditioner.sv - conditions five loop detectors into controller sensor requests
// Starvation alarms are built only when TSC_WAIT_ALARM_EN is defined.
module traffic_sensor_conditioner
  import light_package::*;
#(
  parameter int DEBOUNCE   = 3,
  parameter int CLEAR_HOLD = 2,
  parameter int MAX_WAIT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  raw_det,
  input  colors       e_str_light,
  input  colors       w_str_light,
  input  colors       e_left_light,
  input  colors       w_left_light,
  input  colors       ns_light,
  output logic        e_str_sensor,
  output logic        w_str_sensor,
  output logic        e_left_sensor,
  output logic        w_left_sensor,
  output logic        ns_sensor,
  output logic [4:0]  wait_alarm
);

  logic [NUM_LANES-1:0] is_green;
  logic [NUM_LANES-1:0] sensor;

  assign is_green[LANE_E_STR]  = (e_str_light  == green);
  assign is_green[LANE_W_STR]  = (w_str_light  == green);
  assign is_green[LANE_E_LEFT] = (e_left_light == green);
  assign is_green[LANE_W_LEFT] = (w_left_light == green);
  assign is_green[LANE_NS]     = (ns_light     == green);

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    sensor_lane #(
      .DEBOUNCE   (DEBOUNCE),
      .CLEAR_HOLD (CLEAR_HOLD),
      .MAX_WAIT   (MAX_WAIT)
    ) u_lane (
      .clk          (clk),
      .rst_ni       (reset),
      .raw_i        (raw_det[i]),
      .is_green_i   (is_green[i]),
      .sensor_o     (sensor[i]),
      .wait_alarm_o (wait_alarm[i])
    );
  end

  assign e_str_sensor  = sensor[LANE_E_STR];
  assign w_str_sensor  = sensor[LANE_W_STR];
  assign e_left_sensor = sensor[LANE_E_LEFT];
  assign w_left_sensor = sensor[LANE_W_LEFT];
  assign ns_sensor     = sensor[LANE_NS];

endmodule
